// File: rtl/instr_mem_loader.sv
// Byte-stream loader that assembles little-endian words and writes them into instruction memory.
// Optional trailing XOR checksum byte is enabled with the LOADER_CHECKSUM_EN macro.
module instr_mem_loader #(
    parameter int unsigned MEM_WORDS = 128
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        Start,
    input  logic [7:0]  ByteIn,
    input  logic        ByteValid,
    output logic        ByteReady,
    output logic        IM_WE,
    output logic [31:0] IM_WA,
    output logic [31:0] IM_WD,
    output logic        CpuHold,
    output logic        Done,
    output logic        Error
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS + 1);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, CHK, FIN} state_t;
`else
    typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, FIN} state_t;
`endif

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   n_q, n_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   idx_next;
    logic [1:0]         byte_cnt_q, byte_cnt_d;
    logic [31:0]        word_q, word_d;
    logic [31:0]        wa_q, wa_d;
    logic [31:0]        wd_q, wd_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               accept;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]         csum_q, csum_d;
`endif

    assign accept = ByteValid && ByteReady;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            n_q        <= '0;
            idx_q      <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            wa_q       <= '0;
            wd_q       <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            idx_q      <= idx_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            wa_q       <= wa_d;
            wd_q       <= wd_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        idx_d      = idx_q;
        idx_next   = idx_q + IDX_W'(1);
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        wa_d       = wa_q;
        wd_d       = wd_q;
        done_d     = done_q;
        err_d      = err_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            IDLE, FIN: begin
                if (Start) begin
                    state_d    = LEN;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    idx_d      = '0;
                    byte_cnt_d = '0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d     = '0;
`endif
                end
            end
            LEN: begin
                if (accept) begin
                    if (32'(ByteIn) > MEM_WORDS) begin
                        err_d   = 1'b1;
                        state_d = FIN;
                    end else begin
                        // A zero length byte means a full memory image.
                        n_d     = (ByteIn == 8'd0) ? IDX_W'(MEM_WORDS) : IDX_W'(ByteIn);
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    word_d[{byte_cnt_q, 3'b000} +: 8] = ByteIn;
                    byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ ByteIn;
`endif
                    // Address and data are captured here so they are stable during WRITE and hold afterwards.
                    if (byte_cnt_q == 2'd3) begin
                        wa_d    = 32'({idx_q, 2'b00});
                        wd_d    = {ByteIn, word_q[23:0]};
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                idx_d = idx_next;
                if (idx_next < n_q) begin
                    state_d = DATA;
                end else begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = CHK;
`else
                    done_d  = 1'b1;
                    state_d = FIN;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                if (accept) begin
                    if (ByteIn == csum_q) begin
                        done_d = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                    end
                    state_d = FIN;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ByteReady = 1'b0;
        CpuHold   = 1'b0;
        IM_WE     = 1'b0;
        case (state_q)
            LEN, DATA: begin
                ByteReady = 1'b1;
                CpuHold   = 1'b1;
            end
            WRITE: begin
                IM_WE   = 1'b1;
                CpuHold = 1'b1;
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                ByteReady = 1'b1;
                CpuHold   = 1'b1;
            end
`endif
            default: ;
        endcase
        IM_WA = wa_q;
        IM_WD = wd_q;
        Done  = done_q;
        Error = err_q;
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed self-checking bench for instr_mem_loader; checksum expectations follow LOADER_CHECKSUM_EN.
module tb_instr_mem_loader;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        Start;
    logic [7:0]  ByteIn;
    logic        ByteValid;
    logic        ByteReady;
    logic        IM_WE;
    logic [31:0] IM_WA;
    logic [31:0] IM_WD;
    logic        CpuHold;
    logic        Done;
    logic        Error;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] wr_q[$];
    logic [7:0]  stream [9];

    instr_mem_loader #(.MEM_WORDS(128)) dut (
        .CLK(CLK), .RESET(RESET), .Start(Start), .ByteIn(ByteIn), .ByteValid(ByteValid),
        .ByteReady(ByteReady), .IM_WE(IM_WE), .IM_WA(IM_WA), .IM_WD(IM_WD),
        .CpuHold(CpuHold), .Done(Done), .Error(Error)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (IM_WE === 1'b1) wr_q.push_back({IM_WA, IM_WD});
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic start_session;
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int unsigned waited = 0;
        bit ok = 1'b0;
        ByteIn    = b;
        ByteValid = 1'b1;
        while (!ok && waited < 200) begin
            @(negedge CLK);
            if (ByteReady === 1'b1) ok = 1'b1;
            else waited++;
        end
        if (!ok) check_eq("ready_timeout", 32'(ByteReady), 32'd1);
        tick();
    endtask

    task automatic expect_write(input string tag, input int k, input logic [31:0] wa, input logic [31:0] wd);
        if (k < wr_q.size()) begin
            check_eq({tag, "_wa"}, wr_q[k][63:32], wa);
            check_eq({tag, "_wd"}, wr_q[k][31:0], wd);
        end else begin
            check_eq({tag, "_missing"}, 32'(wr_q.size()), 32'(k + 1));
        end
    endtask

    // Sends the 9-byte reference stream; with toggle set, ByteValid drops for one cycle after each byte.
    task automatic send_stream(input bit toggle, input bit start_in_gap);
        for (int i = 0; i < 9; i++) begin
            send_byte(stream[i]);
            if (toggle) begin
                ByteValid = 1'b0;
                if (start_in_gap && i == 2) Start = 1'b1;
                tick();
                Start = 1'b0;
            end
        end
        ByteValid = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_ready"}, 32'(ByteReady), 32'd0);
        check_eq({tag, "_we"}, 32'(IM_WE), 32'd0);
        check_eq({tag, "_wa"}, IM_WA, 32'd0);
        check_eq({tag, "_wd"}, IM_WD, 32'd0);
        check_eq({tag, "_hold"}, 32'(CpuHold), 32'd0);
        check_eq({tag, "_done"}, 32'(Done), 32'd0);
        check_eq({tag, "_err"}, 32'(Error), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0]  b0, b1, b2, b3, x;
        stream = '{8'h02, 8'h08, 8'h12, 8'h9F, 8'hE5, 8'h91, 8'h01, 8'h02, 8'hE0};
        RESET = 1'b1; Start = 1'b0; ByteIn = 8'h00; ByteValid = 1'b0;
        tick(); tick();
        RESET = 1'b0;
        @(negedge CLK);
        check_reset_state("por");

        // Basic two-word session, back-to-back bytes
        wr_q.delete();
        start_session();
        check_eq("s1_hold_len", 32'(CpuHold), 32'd1);
        check_eq("s1_ready_len", 32'(ByteReady), 32'd1);
        send_stream(1'b0, 1'b0);
        @(negedge CLK);
        check_eq("s1_we", 32'(IM_WE), 32'd1);
        check_eq("s1_wa", IM_WA, 32'h4);
        check_eq("s1_wd", IM_WD, 32'hE002_0191);
`ifdef LOADER_CHECKSUM_EN
        @(negedge CLK);
        check_eq("s1_chk_done", 32'(Done), 32'd0);
        check_eq("s1_chk_hold", 32'(CpuHold), 32'd1);
        send_byte(8'h12);
        ByteValid = 1'b0;
`endif
        @(negedge CLK);
        check_eq("s1_done", 32'(Done), 32'd1);
        check_eq("s1_err", 32'(Error), 32'd0);
        check_eq("s1_hold_fin", 32'(CpuHold), 32'd0);
        check_eq("s1_we_fin", 32'(IM_WE), 32'd0);
        check_eq("s1_wd_hold", IM_WD, 32'hE002_0191);
        repeat (3) tick();
        check_eq("s1_done_held", 32'(Done), 32'd1);
        check_eq("s1_nwr", 32'(wr_q.size()), 32'd2);
        expect_write("s1_w0", 0, 32'h0, 32'hE59F_1208);
        expect_write("s1_w1", 1, 32'h4, 32'hE002_0191);

`ifdef LOADER_CHECKSUM_EN
        // Corrupted checksum: both writes still occur, Error reported
        wr_q.delete();
        start_session();
        check_eq("s2_done_clr", 32'(Done), 32'd0);
        send_stream(1'b0, 1'b0);
        send_byte(8'h13);
        ByteValid = 1'b0;
        @(negedge CLK);
        check_eq("s2_err", 32'(Error), 32'd1);
        check_eq("s2_done", 32'(Done), 32'd0);
        check_eq("s2_hold", 32'(CpuHold), 32'd0);
        tick();
        check_eq("s2_nwr", 32'(wr_q.size()), 32'd2);
        expect_write("s2_w0", 0, 32'h0, 32'hE59F_1208);
        expect_write("s2_w1", 1, 32'h4, 32'hE002_0191);
`endif

        // Oversized length
        wr_q.delete();
        start_session();
        check_eq("s3_done_clr", 32'(Done), 32'd0);
        send_byte(8'h81);
        ByteValid = 1'b0;
        @(negedge CLK);
        check_eq("s3_err", 32'(Error), 32'd1);
        check_eq("s3_done", 32'(Done), 32'd0);
        check_eq("s3_hold", 32'(CpuHold), 32'd0);
        repeat (3) tick();
        check_eq("s3_nwr", 32'(wr_q.size()), 32'd0);

        // Length 0 means a full 128-word image
        wr_q.delete();
        start_session();
        check_eq("s4_err_clr", 32'(Error), 32'd0);
        send_byte(8'h00);
        x = 8'h00;
        for (int i = 0; i < 128; i++) begin
            b0 = 8'(i); b1 = ~8'(i); b2 = 8'h3C ^ 8'(i); b3 = 8'(i * 3);
            send_byte(b0); send_byte(b1); send_byte(b2); send_byte(b3);
            x = x ^ b0 ^ b1 ^ b2 ^ b3;
        end
`ifdef LOADER_CHECKSUM_EN
        @(negedge CLK);
        send_byte(x);
`endif
        ByteValid = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check_eq("s4_done", 32'(Done), 32'd1);
        check_eq("s4_err", 32'(Error), 32'd0);
        tick();
        check_eq("s4_nwr", 32'(wr_q.size()), 32'd128);
        for (int i = 0; i < 128; i++) begin
            b0 = 8'(i); b1 = ~8'(i); b2 = 8'h3C ^ 8'(i); b3 = 8'(i * 3);
            expect_write($sformatf("s4_w%0d", i), i, 32'(i * 4), {b3, b2, b1, b0});
        end

        // ByteValid toggling, with a Start pulse mid-session that must be ignored
        wr_q.delete();
        start_session();
        send_stream(1'b1, 1'b1);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h12);
        ByteValid = 1'b0;
`endif
        repeat (2) @(negedge CLK);
        check_eq("s5_done", 32'(Done), 32'd1);
        check_eq("s5_err", 32'(Error), 32'd0);
        tick();
        check_eq("s5_nwr", 32'(wr_q.size()), 32'd2);
        expect_write("s5_w0", 0, 32'h0, 32'hE59F_1208);
        expect_write("s5_w1", 1, 32'h4, 32'hE002_0191);

        // Reset mid-word, then a clean one-word session
        start_session();
        send_byte(8'h01); send_byte(8'hAA); send_byte(8'hBB);
        ByteValid = 1'b0;
        wr_q.delete();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        @(negedge CLK);
        check_reset_state("s6_rst");
        tick();
        start_session();
        send_byte(8'h01); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h44);
`endif
        ByteValid = 1'b0;
        repeat (2) @(negedge CLK);
        check_eq("s6_done", 32'(Done), 32'd1);
        check_eq("s6_err", 32'(Error), 32'd0);
        tick();
        check_eq("s6_nwr", 32'(wr_q.size()), 32'd1);
        expect_write("s6_w0", 0, 32'h0, 32'h4433_2211);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
